// File: rtl/rice_core_trap_ctrl.sv
// rice_core_trap_ctrl
//   Machine-mode trap controller: privilege level, M-mode trap CSRs,
//   exception/interrupt arbitration, mret handling and WFI sleep.
//
//   Build option: define RICE_CORE_TRAP_VECTORED_EN to make mtvec.mode
//   writable (0/1) and enable vectored interrupt targets. Without it, mode
//   reads 0 and every trap goes to mtvec base.
//
// Ports
//   i_clk, i_rst_n          clock, async active-low reset
//   i_enable                core enable; low forces M / RUN, no traps
//   i_pc, i_exception,      trap inputs from the pipeline
//   i_tval, i_interruptible
//   i_mret, i_wfi           retiring mret / wfi
//   i_msip/i_mtip/i_meip,   interrupt levels
//   i_local_irq
//   o_privilege_level       current privilege (3 = M, 0 = U)
//   o_redirect(_pc)         one-cycle fetch redirect and its target
//   o_sleep                 core halted in WFI
//   i_csr_* / o_csr_*       single-request CSR port, 1-cycle registered reply
//
// FSM states
//   state    | meaning
//   ST_RUN   | core running, traps / mret / wfi accepted
//   ST_SLEEP | halted by wfi until (mip & mie) != 0

module rice_core_trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int EXC_WIDTH   = 16,
  parameter int N_LOCAL_IRQ = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [XLEN-1:0]        i_pc,
  input  logic [EXC_WIDTH-1:0]   i_exception,
  input  logic [XLEN-1:0]        i_tval,
  input  logic                   i_interruptible,
  input  logic                   i_mret,
  input  logic                   i_wfi,
  input  logic                   i_msip,
  input  logic                   i_mtip,
  input  logic                   i_meip,
  input  logic [N_LOCAL_IRQ-1:0] i_local_irq,
  output logic [1:0]             o_privilege_level,
  output logic                   o_redirect,
  output logic [XLEN-1:0]        o_redirect_pc,
  output logic                   o_sleep,
  input  logic                   i_csr_valid,
  input  logic                   i_csr_write,
  input  logic [11:0]            i_csr_addr,
  input  logic [XLEN-1:0]        i_csr_wdata,
  output logic                   o_csr_ack,
  output logic [XLEN-1:0]        o_csr_rdata,
  output logic                   o_csr_error
);

  // 6 bits covers local lines up to code 31 and exception codes up to 63.
  localparam int          CODE_W = 6;
  localparam logic [1:0]  PRIV_M = 2'd3;
  localparam logic [1:0]  PRIV_U = 2'd0;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;

  typedef enum logic {ST_RUN, ST_SLEEP} state_t;

  state_t state, state_nxt;

  logic [1:0]        priv;
  logic              st_mie, st_mpie;
  logic [1:0]        st_mpp;
  logic [XLEN-1:0]   mie_r;
  logic [XLEN-3:0]   mtvec_base;
  logic              mtvec_mode;
  logic [XLEN-1:0]   mscratch, mepc, mtval;
  logic              mcause_intr;
  logic [CODE_W-1:0] mcause_code;

  logic [XLEN-1:0]   irq_mask, mip, irq_pend, mepc_rd, trap_base, trap_pc, csr_rd;
  logic [CODE_W-1:0] exc_code, irq_code, trap_code;
  logic              run, take_exc, take_int, take_trap, trap_intr;
  logic              do_mret, do_wfi, csr_err, csr_we;

  // Implemented interrupt bits, and the live pending view (mip).
  always_comb begin
    irq_mask     = '0;
    irq_mask[3]  = 1'b1;
    irq_mask[7]  = 1'b1;
    irq_mask[11] = 1'b1;
    mip          = '0;
    mip[3]       = i_msip;
    mip[7]       = i_mtip;
    mip[11]      = i_meip;
    for (int k = 0; k < N_LOCAL_IRQ; k++) begin
      irq_mask[16+k] = 1'b1;
      mip[16+k]      = i_local_irq[k];
    end
  end

  assign irq_pend = mip & mie_r;

  // Lowest set exception index wins: scan downward, last hit sticks.
  always_comb begin
    exc_code = '0;
    for (int i = EXC_WIDTH-1; i >= 0; i--)
      if (i_exception[i]) exc_code = CODE_W'(i);
  end

  // Assigned lowest priority first so the highest priority source sticks:
  // locals (higher index wins) < MTI < MSI < MEI.
  always_comb begin
    irq_code = '0;
    for (int k = 0; k < N_LOCAL_IRQ; k++)
      if (irq_pend[16+k]) irq_code = CODE_W'(16 + k);
    if (irq_pend[7])  irq_code = CODE_W'(7);
    if (irq_pend[3])  irq_code = CODE_W'(3);
    if (irq_pend[11]) irq_code = CODE_W'(11);
  end

  assign run       = i_enable && (state == ST_RUN);
  assign take_exc  = run && (|i_exception);
  assign take_int  = run && i_interruptible && (|irq_pend) && (st_mie || priv == PRIV_U);
  assign take_trap = take_exc || take_int;
  assign trap_intr = !take_exc;
  assign trap_code = take_exc ? exc_code : irq_code;
  assign do_mret   = run && i_mret && !take_trap;
  assign do_wfi    = run && i_wfi && !take_trap && !i_mret;

  assign mepc_rd   = mepc & ~XLEN'(3);
  assign trap_base = {mtvec_base, 2'b00};
  assign trap_pc   = (mtvec_mode && trap_intr) ? trap_base + (XLEN'(trap_code) << 2) : trap_base;

  always_comb begin
    csr_rd  = '0;
    csr_err = 1'b0;
    case (i_csr_addr)
      A_MSTATUS: begin
        csr_rd[3]     = st_mie;
        csr_rd[7]     = st_mpie;
        csr_rd[12:11] = st_mpp;
      end
      A_MIE:      csr_rd = mie_r;
      A_MTVEC:    csr_rd = {mtvec_base, 1'b0, mtvec_mode};
      A_MSCRATCH: csr_rd = mscratch;
      A_MEPC:     csr_rd = mepc_rd;
      A_MCAUSE: begin
        csr_rd[XLEN-1]     = mcause_intr;
        csr_rd[CODE_W-1:0] = mcause_code;
      end
      A_MTVAL:    csr_rd = mtval;
      A_MIP: begin
        csr_rd  = mip;
        csr_err = i_csr_write;
      end
      default:    csr_err = 1'b1;
    endcase
  end

  assign csr_we = i_csr_valid && i_csr_write && !csr_err;

`ifndef RICE_CORE_TRAP_VECTORED_EN
  assign mtvec_mode = 1'b0;
`endif

  // CSR writes come first; trap/mret assignments later in the block override
  // only the fields the hardware event touches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      priv          <= PRIV_M;
      st_mie        <= 1'b0;
      st_mpie       <= 1'b0;
      st_mpp        <= PRIV_M;
      mie_r         <= '0;
      mtvec_base    <= '0;
`ifdef RICE_CORE_TRAP_VECTORED_EN
      mtvec_mode    <= 1'b0;
`endif
      mscratch      <= '0;
      mepc          <= '0;
      mcause_intr   <= 1'b0;
      mcause_code   <= '0;
      mtval         <= '0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
    end else begin
      o_redirect <= 1'b0;
      if (csr_we) begin
        case (i_csr_addr)
          A_MSTATUS: begin
            st_mie  <= i_csr_wdata[3];
            st_mpie <= i_csr_wdata[7];
            st_mpp  <= (i_csr_wdata[12:11] == PRIV_U) ? PRIV_U : PRIV_M;
          end
          A_MIE: mie_r <= i_csr_wdata & irq_mask;
          A_MTVEC: begin
            mtvec_base <= i_csr_wdata[XLEN-1:2];
`ifdef RICE_CORE_TRAP_VECTORED_EN
            mtvec_mode <= (i_csr_wdata[1:0] == 2'd1);
`endif
          end
          A_MSCRATCH: mscratch <= i_csr_wdata;
          A_MEPC:     mepc     <= i_csr_wdata;
          A_MCAUSE: begin
            mcause_intr <= i_csr_wdata[XLEN-1];
            mcause_code <= i_csr_wdata[CODE_W-1:0];
          end
          A_MTVAL:    mtval    <= i_csr_wdata;
          default: ;
        endcase
      end
      if (!i_enable) begin
        priv <= PRIV_M;
      end else if (take_trap) begin
        mepc          <= i_pc;
        mcause_intr   <= trap_intr;
        mcause_code   <= trap_code;
        mtval         <= take_exc ? i_tval : '0;
        st_mpie       <= st_mie;
        st_mie        <= 1'b0;
        st_mpp        <= priv;
        priv          <= PRIV_M;
        o_redirect    <= 1'b1;
        o_redirect_pc <= trap_pc;
      end else if (do_mret) begin
        priv          <= st_mpp;
        st_mie        <= st_mpie;
        st_mpie       <= 1'b1;
        st_mpp        <= PRIV_U;
        o_redirect    <= 1'b1;
        o_redirect_pc <= mepc_rd;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_csr_ack   <= 1'b0;
      o_csr_error <= 1'b0;
      o_csr_rdata <= '0;
    end else begin
      o_csr_ack   <= i_csr_valid;
      o_csr_error <= i_csr_valid && csr_err;
      o_csr_rdata <= (i_csr_valid && !csr_err) ? csr_rd : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  // Wake ignores mstatus.MIE; whether the wake source then traps is decided
  // by the normal acceptance rules once back in RUN.
  always_comb begin
    state_nxt = state;
    if (!i_enable) begin
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (do_wfi) state_nxt = ST_SLEEP;
        ST_SLEEP: if (|irq_pend) state_nxt = ST_RUN;
        default:  state_nxt = ST_RUN;
      endcase
    end
  end

  assign o_sleep           = (state == ST_SLEEP);
  assign o_privilege_level = priv;

endmodule

// File: tb/tb_rice_core_trap_ctrl.sv
module tb_rice_core_trap_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_enable;
  logic [31:0] i_pc;
  logic [15:0] i_exception;
  logic [31:0] i_tval;
  logic        i_interruptible, i_mret, i_wfi;
  logic        i_msip, i_mtip, i_meip;
  logic [3:0]  i_local_irq;
  logic [1:0]  o_privilege_level;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_sleep;
  logic        i_csr_valid, i_csr_write;
  logic [11:0] i_csr_addr;
  logic [31:0] i_csr_wdata;
  logic        o_csr_ack;
  logic [31:0] o_csr_rdata;
  logic        o_csr_error;

  int total = 0;
  int bad   = 0;

`ifdef RICE_CORE_TRAP_VECTORED_EN
  localparam logic [31:0] MTVEC_RD = 32'h8000_0101;
  localparam logic [31:0] PC_MEI   = 32'h8000_012C;
  localparam logic [31:0] PC_LOC2  = 32'h8000_0148;
`else
  localparam logic [31:0] MTVEC_RD = 32'h8000_0100;
  localparam logic [31:0] PC_MEI   = 32'h8000_0100;
  localparam logic [31:0] PC_LOC2  = 32'h8000_0100;
`endif

  rice_core_trap_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_pc(i_pc),
    .i_exception(i_exception), .i_tval(i_tval), .i_interruptible(i_interruptible),
    .i_mret(i_mret), .i_wfi(i_wfi), .i_msip(i_msip), .i_mtip(i_mtip), .i_meip(i_meip),
    .i_local_irq(i_local_irq), .o_privilege_level(o_privilege_level),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_sleep(o_sleep),
    .i_csr_valid(i_csr_valid), .i_csr_write(i_csr_write), .i_csr_addr(i_csr_addr),
    .i_csr_wdata(i_csr_wdata), .o_csr_ack(o_csr_ack), .o_csr_rdata(o_csr_rdata),
    .o_csr_error(o_csr_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic csr(input logic wr, input logic [11:0] a, input logic [31:0] d);
    i_csr_valid = 1'b1;
    i_csr_write = wr;
    i_csr_addr  = a;
    i_csr_wdata = d;
    tick();
    i_csr_valid = 1'b0;
    i_csr_write = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_enable = 1'b1; i_pc = '0; i_exception = '0; i_tval = '0;
    i_interruptible = 1'b0; i_mret = 1'b0; i_wfi = 1'b0;
    i_msip = 1'b0; i_mtip = 1'b0; i_meip = 1'b0; i_local_irq = '0;
    i_csr_valid = 1'b0; i_csr_write = 1'b0; i_csr_addr = '0; i_csr_wdata = '0;
    repeat (3) tick();

    // reset state
    chk("rst_priv", o_privilege_level, 2'd3);
    chk("rst_redirect", o_redirect, 1'b0);
    chk("rst_redirect_pc", o_redirect_pc, 32'h0);
    chk("rst_sleep", o_sleep, 1'b0);
    chk("rst_ack", o_csr_ack, 1'b0);
    chk("rst_err", o_csr_error, 1'b0);
    chk("rst_rdata", o_csr_rdata, 32'h0);
    i_rst_n = 1'b1;
    tick();

    // CSR port basics
    csr(1'b0, 12'h300, 0);
    chk("mstatus_ack", o_csr_ack, 1'b1);
    chk("mstatus_rst", o_csr_rdata, 32'h0000_1800);
    chk("mstatus_err", o_csr_error, 1'b0);
    tick();
    chk("ack_pulse", o_csr_ack, 1'b0);
    csr(1'b0, 12'h7FF, 0);
    chk("unmapped_err", o_csr_error, 1'b1);
    chk("unmapped_ack", o_csr_ack, 1'b1);
    csr(1'b1, 12'h344, 32'hFFFF_FFFF);
    chk("mip_write_err", o_csr_error, 1'b1);
    csr(1'b1, 12'h305, 32'h8000_0101);
    csr(1'b0, 12'h305, 0);
    chk("mtvec_rd", o_csr_rdata, MTVEC_RD);

    // synchronous exception: lowest index of 0x0006 is code 1
    i_exception = 16'h0006; i_pc = 32'h40; i_tval = 32'h1234;
    tick();
    i_exception = '0;
    chk("exc_redirect", o_redirect, 1'b1);
    chk("exc_pc", o_redirect_pc, 32'h8000_0100);
    chk("exc_priv", o_privilege_level, 2'd3);
    csr(1'b0, 12'h342, 0);
    chk("exc_redirect_pulse", o_redirect, 1'b0);
    chk("exc_mcause", o_csr_rdata, 32'h1);
    csr(1'b0, 12'h341, 0);
    chk("exc_mepc", o_csr_rdata, 32'h40);
    csr(1'b0, 12'h343, 0);
    chk("exc_mtval", o_csr_rdata, 32'h1234);
    csr(1'b0, 12'h300, 0);
    chk("exc_mstatus", o_csr_rdata, 32'h0000_1800);

    // MEI beats MTI
    csr(1'b1, 12'h304, 32'h888);
    csr(1'b1, 12'h300, 32'h8);
    i_mtip = 1'b1; i_meip = 1'b1; i_interruptible = 1'b1; i_pc = 32'h80;
    tick();
    i_mtip = 1'b0; i_meip = 1'b0; i_interruptible = 1'b0;
    chk("mei_redirect", o_redirect, 1'b1);
    chk("mei_pc", o_redirect_pc, PC_MEI);
    csr(1'b0, 12'h342, 0);
    chk("mei_mcause", o_csr_rdata, 32'h8000_000B);
    csr(1'b0, 12'h343, 0);
    chk("mei_mtval", o_csr_rdata, 32'h0);
    csr(1'b0, 12'h341, 0);
    chk("mei_mepc", o_csr_rdata, 32'h80);
    csr(1'b0, 12'h300, 0);
    chk("mei_mstatus", o_csr_rdata, 32'h0000_1880);

    // MPP WARL, then mret to U
    csr(1'b1, 12'h300, 32'h0000_0800);
    csr(1'b0, 12'h300, 0);
    chk("mpp_warl", o_csr_rdata, 32'h0000_1800);
    csr(1'b1, 12'h300, 32'h0000_0080);
    i_mret = 1'b1;
    tick();
    i_mret = 1'b0;
    chk("mret_redirect", o_redirect, 1'b1);
    chk("mret_pc", o_redirect_pc, 32'h80);
    chk("mret_priv", o_privilege_level, 2'd0);
    csr(1'b0, 12'h300, 0);
    chk("mret_mstatus", o_csr_rdata, 32'h0000_0088);

    // exception code 2 + MSI + CSR write to mepc, all in one cycle from U
    i_msip = 1'b1; i_interruptible = 1'b1; i_exception = 16'h0104;
    i_pc = 32'h200; i_tval = 32'hBEEF;
    csr(1'b1, 12'h341, 32'h123);
    i_msip = 1'b0; i_interruptible = 1'b0; i_exception = '0;
    chk("mix_redirect", o_redirect, 1'b1);
    chk("mix_pc", o_redirect_pc, 32'h8000_0100);
    chk("mix_priv", o_privilege_level, 2'd3);
    chk("mix_csr_ack", o_csr_ack, 1'b1);
    csr(1'b0, 12'h341, 0);
    chk("mix_mepc", o_csr_rdata, 32'h200);
    csr(1'b0, 12'h342, 0);
    chk("mix_mcause", o_csr_rdata, 32'h2);
    csr(1'b0, 12'h343, 0);
    chk("mix_mtval", o_csr_rdata, 32'hBEEF);
    csr(1'b0, 12'h300, 0);
    chk("mix_mstatus", o_csr_rdata, 32'h0000_0080);

    // WFI with MIE = 0, wake on MSI without trapping
    i_wfi = 1'b1;
    tick();
    i_wfi = 1'b0;
    chk("wfi_sleep", o_sleep, 1'b1);
    chk("wfi_no_redirect", o_redirect, 1'b0);
    tick(); tick();
    chk("wfi_hold", o_sleep, 1'b1);
    i_msip = 1'b1;
    tick();
    chk("wake_sleep", o_sleep, 1'b0);
    i_interruptible = 1'b1;
    tick();
    chk("wake_no_trap", o_redirect, 1'b0);
    i_msip = 1'b0; i_interruptible = 1'b0;
    tick();

    // back to U, sleep, then disable
    i_mret = 1'b1;
    tick();
    i_mret = 1'b0;
    chk("mret2_pc", o_redirect_pc, 32'h200);
    chk("mret2_priv", o_privilege_level, 2'd0);
    i_wfi = 1'b1;
    tick();
    i_wfi = 1'b0;
    chk("wfi2_sleep", o_sleep, 1'b1);
    i_enable = 1'b0;
    tick();
    chk("dis_sleep", o_sleep, 1'b0);
    chk("dis_priv", o_privilege_level, 2'd3);
    i_exception = 16'h0001;
    tick();
    chk("dis_no_trap", o_redirect, 1'b0);
    csr(1'b0, 12'h341, 0);
    chk("dis_mepc_kept", o_csr_rdata, 32'h200);
    i_exception = '0;
    i_enable = 1'b1;
    tick();

    // trap beats same-cycle mret
    i_mret = 1'b1; i_exception = 16'h0001; i_pc = 32'h300;
    tick();
    i_mret = 1'b0; i_exception = '0;
    chk("trapmret_pc", o_redirect_pc, 32'h8000_0100);
    csr(1'b0, 12'h342, 0);
    chk("trapmret_mcause", o_csr_rdata, 32'h0);
    csr(1'b0, 12'h300, 0);
    chk("trapmret_mstatus", o_csr_rdata, 32'h0000_1880);

    // locals: higher index wins
    csr(1'b1, 12'h300, 32'h8);
    csr(1'b1, 12'h304, 32'h000F_0000);
    i_local_irq = 4'b0101; i_interruptible = 1'b1; i_pc = 32'h400;
    tick();
    i_local_irq = '0; i_interruptible = 1'b0;
    chk("loc_pc", o_redirect_pc, PC_LOC2);
    csr(1'b0, 12'h342, 0);
    chk("loc_mcause", o_csr_rdata, 32'h8000_0012);

    // MSI beats MTI
    csr(1'b1, 12'h300, 32'h8);
    csr(1'b1, 12'h304, 32'h888);
    i_msip = 1'b1; i_mtip = 1'b1; i_interruptible = 1'b1;
    tick();
    i_msip = 1'b0; i_mtip = 1'b0; i_interruptible = 1'b0;
    csr(1'b0, 12'h342, 0);
    chk("msi_mcause", o_csr_rdata, 32'h8000_0003);

    // reset in the middle of a trap cycle
    csr(1'b1, 12'h340, 32'hCAFE);
    csr(1'b0, 12'h340, 0);
    chk("mscratch_rd", o_csr_rdata, 32'hCAFE);
    i_exception = 16'h0001;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_redirect", o_redirect, 1'b0);
    chk("midrst_priv", o_privilege_level, 2'd3);
    tick();
    i_exception = '0;
    i_rst_n = 1'b1;
    tick();
    chk("midrst_no_commit", o_redirect, 1'b0);
    csr(1'b0, 12'h305, 0);
    chk("midrst_mtvec", o_csr_rdata, 32'h0);
    csr(1'b0, 12'h340, 0);
    chk("midrst_mscratch", o_csr_rdata, 32'h0);
    csr(1'b0, 12'h341, 0);
    chk("midrst_mepc", o_csr_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rice_core_trap_ctrl.md
Name: rice_core_trap_ctrl

Overview:
- Machine-mode trap/environment controller that supersedes the exception-only environment block.
- Owns privilege level, mstatus/mie/mip/mtvec/mscratch/mepc/mcause/mtval.
- Arbitrates synchronous exceptions against prioritised interrupts (standard plus parametrised local lines), supports vectored mtvec and a WFI sleep state.
- Sits beside the core pipeline; the CSR unit reaches it over a single-request CSR port.

Parameters:
- XLEN, 32, data/address width (32 or 64).
- EXC_WIDTH, 16, width of the exception vector; bit index equals the mcause exception code.
- N_LOCAL_IRQ, 4, local interrupt lines (0..16); line k maps to mcause/mip/mie bit 16+k.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_enable  in  1  core enable; low forces idle state.
- i_pc  in  XLEN  pc of the faulting instruction, or of the next instruction at an interruptible boundary.
- i_exception  in  EXC_WIDTH  exception request vector.
- i_tval  in  XLEN  trap value for the exception.
- i_interruptible  in  1  instruction boundary; interrupts may be taken.
- i_mret  in  1  mret retiring.
- i_wfi  in  1  wfi retiring.
- i_msip/i_mtip/i_meip  in  1 each  standard interrupt levels.
- i_local_irq  in  N_LOCAL_IRQ  local interrupt levels.
- o_privilege_level  out  2  current privilege (M=3, U=0).
- o_redirect  out  1  one-cycle pulse: fetch must jump to o_redirect_pc.
- o_redirect_pc  out  XLEN  trap vector or mepc.
- o_sleep  out  1  core halted in WFI.
- i_csr_valid  in  1  CSR request.
- i_csr_write  in  1  1=write, 0=read.
- i_csr_addr  in  12  CSR address.
- i_csr_wdata  in  XLEN  write data.
- o_csr_ack  out  1  one-cycle response pulse.
- o_csr_rdata  out  XLEN  read data.
- o_csr_error  out  1  unmapped address or write to read-only CSR.

Behaviour:
- Reset values:
  - privilege = M; FSM = RUN.
  - o_redirect, o_sleep, o_csr_ack, o_csr_error = 0; o_redirect_pc, o_csr_rdata = 0.
  - All CSRs = 0 except mstatus.MPP = 3.
- CSR map:
  - 0x300 mstatus: MIE b3, MPIE b7, MPP b12:11 (WARL: 0 or 3; other values write 3).
  - 0x304 mie; 0x305 mtvec (base b[XLEN-1:2], mode b[1:0]); 0x340 mscratch; 0x341 mepc (b[1:0] read 0); 0x342 mcause (interrupt flag MSB, code below); 0x343 mtval.
  - 0x344 mip is read-only: {local, MEIP b11, MTIP b7, MSIP b3}.
  - Unimplemented bits read 0.
- CSR port:
  - Request accepted every cycle while i_csr_valid; ack, rdata and error are registered with 1-cycle latency.
  - Error on any other address, or on a write to 0x344; failed writes have no effect.
  - Read returns the pre-write value.
- Trap selection in cycle T (combinational):
  - Exception: i_exception != 0; lowest set index wins and becomes the code.
  - Interrupt: i_interruptible && (mip & mie) != 0 && (mstatus.MIE || privilege == U).
  - Interrupt priority: MEI(11) > MSI(3) > MTI(7) > local, highest index first.
  - An exception always beats a same-cycle interrupt.
- Trap commit at edge T+1:
  - mepc = i_pc; mcause = {intr, code}; mtval = i_tval for exceptions, 0 for interrupts.
  - MPIE = MIE; MIE = 0; MPP = privilege; privilege = M.
  - o_redirect = 1 for exactly one cycle.
  - o_redirect_pc = base<<2, or base<<2 + 4*code when mode = 1 and the trap is an interrupt.
- mret (no trap the same cycle): at T+1, privilege = MPP, MIE = MPIE, MPIE = 1, MPP = U(0), o_redirect = 1, o_redirect_pc = mepc.
- Trap and mret in the same cycle: trap wins and mret is ignored.
- Trap or mret and a CSR write in the same cycle: hardware update wins for the fields it touches; other fields take the CSR write.
- FSM RUN -> SLEEP:
  - Taken at i_wfi when no trap is taken that cycle; o_sleep = 1 from T+1.
  - SLEEP -> RUN when (mip & mie) != 0, regardless of MIE; o_sleep drops the next cycle.
  - Interrupt acceptance then follows the normal rules.
- i_enable low: synchronous return to privilege M, FSM RUN, o_redirect/o_sleep = 0, traps suppressed; CSR contents are retained.
- Reset asserted mid-trap: all state returns to reset values immediately, with no partial commit.

Optional Feature:
- Macro: RICE_CORE_TRAP_VECTORED_EN.
- Defined: mtvec.mode is writable as 0 or 1 (values 2 and 3 write 0); vectored offsets apply.
- Undefined: mode is hardwired 0, reads 0, and every trap goes to base<<2.

Test Plan:
- Reset, then read 0x300 -> ack next cycle, rdata = 0x0000_1800; read 0x7FF -> o_csr_error = 1.
- mtvec = 0x8000_0100; i_exception = 0x0006 at pc 0x40 -> mcause = 1, mepc = 0x40, o_redirect_pc = 0x8000_0100, privilege M, MIE 0.
- MIE = 1, mie = 0x888, i_mtip and i_meip both high, mode = 1 with EN defined -> mcause = 0x8000_000B, pc = base + 0x2C; with EN undefined pc = base.
- Privilege U with MPP = 0, issue mret after a trap -> redirect to mepc, privilege 0, MIE = old MPIE, MPIE = 1.
- wfi with MIE = 0, mie.MSIE = 1 -> o_sleep = 1; raise i_msip -> o_sleep = 0 next cycle, no trap taken.
- Same cycle exception code 2 + interrupt + CSR write mepc = 0x123 -> exception taken, mepc = i_pc.
